// File: rtl/fetch_buffer.sv
// fetch_buffer: PC owner issuing 1-cycle-latency imem reads into a small {instr,pc} FIFO for decode
module fetch_buffer #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_instr,
  output logic [31:0] out_pc,
  output logic [31:0] out_pc_plus4
);
  localparam int AW = $clog2(DEPTH);
  logic [31:0]   pc;
  logic [31:0]   inflight_pc;
  logic          inflight;
  logic [AW:0]   count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   instr_mem [DEPTH];
  logic [31:0]   pc_mem [DEPTH];
  logic          push;
  logic          pop;
  always_comb begin
    imem_req     = !rst && !redirect_valid && (int'(count) + int'(inflight) < DEPTH);
    imem_addr    = pc;
    out_valid    = (count != '0) && !redirect_valid && !rst;
    push         = inflight && !redirect_valid && !rst;
    pop          = out_valid && out_ready;
    out_instr    = instr_mem[rd_ptr];
    out_pc       = pc_mem[rd_ptr];
    out_pc_plus4 = pc_mem[rd_ptr] + 32'd4;
  end
  always_ff @(posedge clk) begin
    if (push) begin
      instr_mem[wr_ptr] <= imem_rdata;
      pc_mem[wr_ptr]    <= inflight_pc;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inflight    <= 1'b0;
      inflight_pc <= RESET_PC;
      count       <= '0;
      rd_ptr      <= '0;
      wr_ptr      <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc & ~32'h3;
      inflight <= 1'b0;
      count    <= '0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
    end else begin
      pc          <= imem_req ? pc + 32'd4 : pc;
      inflight    <= imem_req;
      inflight_pc <= imem_req ? pc : inflight_pc;
      count       <= count + (AW+1)'(push) - (AW+1)'(pop);
      rd_ptr      <= rd_ptr + AW'(pop);
      wr_ptr      <= wr_ptr + AW'(push);
    end
  end
endmodule

// File: tb/tb_fetch_buffer.sv
// tb_fetch_buffer: directed and randomized checks of fetch_buffer against a queue-based model
module tb_fetch_buffer;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst = 1'b1;
  logic redirect_valid = 1'b0;
  logic out_ready = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic imem_req, out_valid, w_req, w_valid;
  logic [31:0] imem_addr, imem_rdata, out_instr, out_pc, out_pc_plus4;
  logic [31:0] w_addr, w_rdata, w_instr, w_pc, w_pc4;
  int checks = 0;
  int failures = 0;
  int epoch = 0;
  fetch_buffer #(.DEPTH(4), .RESET_PC(32'h0000_0000)) u_dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(out_valid),
    .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc), .out_pc_plus4(out_pc_plus4)
  );
  fetch_buffer #(.DEPTH(4), .RESET_PC(32'hFFFF_FFF8)) u_wrap (
    .clk(clk), .rst(rst), .imem_req(w_req), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .out_valid(w_valid),
    .out_ready(out_ready), .out_instr(w_instr), .out_pc(w_pc), .out_pc_plus4(w_pc4)
  );
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return 32'h1000_0000 + (a >> 2) + (32'(epoch) << 20);
  endfunction
  always @(posedge clk) begin
    imem_rdata <= imem_req ? mem_word(imem_addr) : 32'hDEAD_BEEF;
    w_rdata    <= w_req ? mem_word(w_addr) : 32'hDEAD_BEEF;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic settle();
    #2;
  endtask
  task automatic do_reset(input logic ready);
    rst = 1'b1;
    redirect_valid = 1'b0;
    out_ready = ready;
    tick();
    tick();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    settle();
    checks++; if (imem_req !== 1'b0) begin failures++; $display("FAIL reset_req got=%b exp=0", imem_req); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    checks++; if (w_valid !== 1'b0 || w_req !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b%b exp=00", w_valid, w_req); end
    tick();
    rst = 1'b0;
    settle();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h0) begin failures++; $display("FAIL release_req got=%b/%h exp=1/00000000", imem_req, imem_addr); end
    checks++; if (w_addr !== 32'hFFFF_FFF8) begin failures++; $display("FAIL release_wrap_addr got=%h exp=fffffff8", w_addr); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL release_valid got=%b exp=0", out_valid); end
  endtask
  task automatic test_stream();
    logic [31:0] e;
    do_reset(1'b1);
    for (int c = 0; c < 10; c++) begin
      settle();
      checks++; if (imem_addr !== 32'(4 * c)) begin failures++; $display("FAIL stream_addr cyc=%0d got=%h exp=%h", c, imem_addr, 32'(4 * c)); end
      checks++; if (out_valid !== (c >= 2)) begin failures++; $display("FAIL stream_valid cyc=%0d got=%b exp=%b", c, out_valid, c >= 2); end
      if (c >= 2) begin
        e = 32'(4 * (c - 2));
        checks++; if (out_pc !== e) begin failures++; $display("FAIL stream_pc cyc=%0d got=%h exp=%h", c, out_pc, e); end
        checks++; if (out_instr !== 32'h1000_0000 + 32'(c - 2)) begin failures++; $display("FAIL stream_instr cyc=%0d got=%h exp=%h", c, out_instr, 32'h1000_0000 + 32'(c - 2)); end
        checks++; if (out_pc_plus4 !== e + 32'd4) begin failures++; $display("FAIL stream_plus4 cyc=%0d got=%h exp=%h", c, out_pc_plus4, e + 32'd4); end
      end
      tick();
    end
  endtask
  task automatic test_stall();
    do_reset(1'b0);
    for (int c = 0; c < 10; c++) begin
      settle();
      checks++; if (imem_req !== (c < 4)) begin failures++; $display("FAIL stall_req cyc=%0d got=%b exp=%b", c, imem_req, c < 4); end
      checks++; if (imem_addr !== 32'(c < 4 ? 4 * c : 16)) begin failures++; $display("FAIL stall_addr cyc=%0d got=%h exp=%h", c, imem_addr, 32'(c < 4 ? 4 * c : 16)); end
      tick();
    end
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      settle();
      checks++; if (out_valid !== 1'b1 || out_pc !== 32'(4 * c)) begin failures++; $display("FAIL drain cyc=%0d got=%b/%h exp=1/%h", c, out_valid, out_pc, 32'(4 * c)); end
      tick();
    end
  endtask
  task automatic test_redirect();
    do_reset(1'b0);
    repeat (4) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0103;
    settle();
    checks++; if (out_valid !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL redir_cycle got=%b/%b exp=0/0", out_valid, imem_req); end
    tick();
    redirect_valid = 1'b0;
    out_ready = 1'b1;
    settle();
    checks++; if (imem_req !== 1'b1 || imem_addr !== 32'h100) begin failures++; $display("FAIL redir_addr got=%b/%h exp=1/00000100", imem_req, imem_addr); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL redir_r1_valid got=%b exp=0", out_valid); end
    tick();
    settle();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL redir_r2_valid got=%b exp=0", out_valid); end
    tick();
    settle();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h100) begin failures++; $display("FAIL redir_r3 got=%b/%h exp=1/00000100", out_valid, out_pc); end
    tick();
    settle();
    checks++; if (out_pc !== 32'h104 || out_instr !== mem_word(32'h104)) begin failures++; $display("FAIL redir_r4 got=%h/%h exp=00000104/%h", out_pc, out_instr, mem_word(32'h104)); end
  endtask
  task automatic test_redirect_pop();
    logic [31:0] e;
    do_reset(1'b1);
    repeat (4) tick();
    redirect_valid = 1'b1;
    redirect_pc = 32'h40;
    settle();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL rp_first_valid got=%b exp=0", out_valid); end
    tick();
    redirect_pc = 32'h80;
    settle();
    checks++; if (out_valid !== 1'b0 || imem_req !== 1'b0) begin failures++; $display("FAIL rp_second got=%b/%b exp=0/0", out_valid, imem_req); end
    tick();
    redirect_valid = 1'b0;
    settle();
    checks++; if (imem_addr !== 32'h80) begin failures++; $display("FAIL rp_addr got=%h exp=00000080", imem_addr); end
    e = 32'h80;
    for (int c = 0; c < 10; c++) begin
      if (out_valid) begin
        checks++; if (out_pc !== e) begin failures++; $display("FAIL rp_pc cyc=%0d got=%h exp=%h", c, out_pc, e); end
        e = e + 32'd4;
      end
      tick();
      settle();
    end
    checks++; if (e !== 32'hA0) begin failures++; $display("FAIL rp_count got=%h exp=000000a0", e); end
  endtask
  task automatic test_wrap();
    logic [31:0] e;
    do_reset(1'b1);
    for (int c = 0; c < 5; c++) begin
      settle();
      checks++; if (w_addr !== 32'hFFFF_FFF8 + 32'(4 * c)) begin failures++; $display("FAIL wrap_addr cyc=%0d got=%h exp=%h", c, w_addr, 32'hFFFF_FFF8 + 32'(4 * c)); end
      if (c >= 2) begin
        e = 32'hFFFF_FFF8 + 32'(4 * (c - 2));
        checks++; if (w_valid !== 1'b1 || w_pc !== e) begin failures++; $display("FAIL wrap_pc cyc=%0d got=%b/%h exp=1/%h", c, w_valid, w_pc, e); end
        checks++; if (w_pc4 !== e + 32'd4) begin failures++; $display("FAIL wrap_plus4 cyc=%0d got=%h exp=%h", c, w_pc4, e + 32'd4); end
        checks++; if (w_instr !== mem_word(e)) begin failures++; $display("FAIL wrap_instr cyc=%0d got=%h exp=%h", c, w_instr, mem_word(e)); end
      end
      tick();
    end
  endtask
  task automatic test_reset_mid();
    epoch = 0;
    do_reset(1'b0);
    repeat (4) tick();
    settle();
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL mid_pre_valid got=%b exp=1", out_valid); end
    rst = 1'b1;
    epoch = 1;
    tick();
    rst = 1'b0;
    out_ready = 1'b1;
    settle();
    checks++; if (out_valid !== 1'b0 || imem_addr !== 32'h0 || imem_req !== 1'b1) begin failures++; $display("FAIL mid_after got=%b/%h/%b exp=0/00000000/1", out_valid, imem_addr, imem_req); end
    tick();
    settle();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL mid_stale_valid got=%b exp=0", out_valid); end
    tick();
    settle();
    checks++; if (out_valid !== 1'b1 || out_pc !== 32'h0 || out_instr !== mem_word(32'h0)) begin failures++; $display("FAIL mid_first got=%b/%h/%h exp=1/00000000/%h", out_valid, out_pc, out_instr, mem_word(32'h0)); end
    tick();
    settle();
    checks++; if (out_pc !== 32'h4 || out_instr !== mem_word(32'h4)) begin failures++; $display("FAIL mid_second got=%h/%h exp=00000004/%h", out_pc, out_instr, mem_word(32'h4)); end
  endtask
  task automatic test_random();
    int iss_cyc[$];
    logic [31:0] iss_pc[$];
    logic [31:0] fetch_pc;
    logic exp_valid, exp_req;
    fetch_pc = 32'h0;
    do_reset(1'b0);
    for (int cyc = 0; cyc < 2000; cyc++) begin
      out_ready = ($urandom % 4) != 0;
      redirect_valid = ($urandom % 12) == 0;
      redirect_pc = $urandom;
      settle();
      exp_valid = !redirect_valid && iss_cyc.size() > 0 && iss_cyc[0] + 2 <= cyc;
      exp_req = !redirect_valid && iss_cyc.size() < 4;
      checks++; if (imem_req !== exp_req) begin failures++; $display("FAIL rnd_req cyc=%0d got=%b exp=%b", cyc, imem_req, exp_req); end
      checks++; if (imem_addr !== fetch_pc) begin failures++; $display("FAIL rnd_addr cyc=%0d got=%h exp=%h", cyc, imem_addr, fetch_pc); end
      checks++; if (out_valid !== exp_valid) begin failures++; $display("FAIL rnd_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_valid); end
      if (exp_valid && out_ready) begin
        checks++; if (out_pc !== iss_pc[0] || out_instr !== mem_word(iss_pc[0]) || out_pc_plus4 !== iss_pc[0] + 32'd4) begin
          failures++; $display("FAIL rnd_pop cyc=%0d got=%h/%h/%h exp=%h/%h/%h", cyc, out_pc, out_instr, out_pc_plus4, iss_pc[0], mem_word(iss_pc[0]), iss_pc[0] + 32'd4);
        end
        void'(iss_cyc.pop_front());
        void'(iss_pc.pop_front());
      end
      if (redirect_valid) begin
        iss_cyc.delete();
        iss_pc.delete();
        fetch_pc = redirect_pc & ~32'h3;
      end else if (exp_req) begin
        iss_cyc.push_back(cyc);
        iss_pc.push_back(fetch_pc);
        fetch_pc = fetch_pc + 32'd4;
      end
      tick();
    end
    redirect_valid = 1'b0;
  endtask
  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_pop();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
